// File: rtl/ahb_burst_master_if.sv
// ahb_burst_master_if: bundles the command, write-data, read-return and AHB-Lite
// bus signals of the burst master. The master modport is the block's view;
// the slave modport is the view of whatever drives it (front end plus fabric).
interface ahb_burst_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
);
   // command channel
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic              cmd_write;
   logic [2:0]        cmd_size;
   logic [2:0]        cmd_burst;
   logic [LEN_W-1:0]  cmd_len;
   // write-data stream
   logic              wd_valid;
   logic              wd_ready;
   logic [DATA_W-1:0] wd_data;
   // read return and completion
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_err;
   logic              done;
   logic              done_err;
   // AHB-Lite
   logic [ADDR_W-1:0] HADDR;
   logic [2:0]        HBURST;
   logic [2:0]        HSIZE;
   logic [1:0]        HTRANS;
   logic              HWRITE;
   logic [DATA_W-1:0] HWDATA;
   logic [DATA_W-1:0] HRDATA;
   logic              HREADY;
   logic              HRESP;

   modport master (
      input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_burst, cmd_len,
      input  wd_valid, wd_data, HRDATA, HREADY, HRESP,
      output cmd_ready, wd_ready, rd_valid, rd_data, rd_err, done, done_err,
      output HADDR, HBURST, HSIZE, HTRANS, HWRITE, HWDATA
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_burst, cmd_len,
      output wd_valid, wd_data, HRDATA, HREADY, HRESP,
      input  cmd_ready, wd_ready, rd_valid, rd_data, rd_err, done, done_err,
      input  HADDR, HBURST, HSIZE, HTRANS, HWRITE, HWDATA
   );
endinterface

// File: rtl/ahb_burst_master.sv
// ahb_burst_master: AHB-Lite burst master. Takes one command, runs it as a
// pipelined address/data burst (INCR/WRAP addressing, HREADY stalls, BUSY on
// write-data starvation) and reports per-beat read status plus a done pulse.
// Optional build macro: AHB_BURST_ABORT_EN -- cancel the rest of the burst on
// an ERROR response instead of running it to completion.
module ahb_burst_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic               HCLK,
   input  logic               HRESETn,
   ahb_burst_master_if.master bus
);
   localparam int MAX_SIZE = $clog2(DATA_W / 8);
   localparam int CNT_W    = (LEN_W + 1 > 5) ? LEN_W + 1 : 5;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_BUSY   = 2'b01;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;

`ifdef AHB_BURST_ABORT_EN
   localparam bit ABORT = 1'b1;
`else
   localparam bit ABORT = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DRAIN} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] haddr_q, haddr_d;
   logic [ADDR_W-1:0] wmask_q;     // wrap-window mask, bound-1
   logic [2:0]        hsize_q, hburst_q;
   logic              hwrite_q, wrap_q, first_q;
   logic [CNT_W-1:0]  left_q;      // address phases still to issue, incl. current
   logic [DATA_W-1:0] hwdata_q, rd_data_q;
   logic              dph_q;       // a data phase is outstanding on the bus
   logic              err_q;       // sticky: some beat of this burst errored
   logic              rd_valid_q, rd_err_q, done_q, done_err_q;

   logic [CNT_W-1:0]  cmd_beats;
   logic [ADDR_W-1:0] cmd_mask, incr;
   logic [1:0]        htrans;
   logic              stall_wr, addr_go, dph_done, err_first;

   // Beat count and wrap mask of the command being offered.
   always_comb begin
      cmd_beats = CNT_W'(1);
      case (bus.cmd_burst)
         3'd1:       cmd_beats = CNT_W'(bus.cmd_len) + CNT_W'(1);
         3'd2, 3'd3: cmd_beats = CNT_W'(4);
         3'd4, 3'd5: cmd_beats = CNT_W'(8);
         3'd6, 3'd7: cmd_beats = CNT_W'(16);
         default:    cmd_beats = CNT_W'(1);
      endcase
      cmd_mask = (ADDR_W'(cmd_beats) << bus.cmd_size) - ADDR_W'(1);
   end

   // Next beat address: linear for INCR, stays inside the aligned window for WRAP.
   always_comb begin
      incr = ADDR_W'(1) << hsize_q;
      if (wrap_q)
         haddr_d = (haddr_q & ~wmask_q) | ((haddr_q + incr) & wmask_q);
      else
         haddr_d = haddr_q + incr;
   end

   // A write beat cannot go out without its data; the stream's valid must hold
   // until accepted, so the IDLE/BUSY substitution stays stable across wait states.
   assign stall_wr  = hwrite_q & ~bus.wd_valid;
   assign addr_go   = (state_q == S_ADDR) & bus.HREADY & ~stall_wr;
   assign dph_done  = dph_q & bus.HREADY;
   assign err_first = dph_q & bus.HRESP & ~bus.HREADY;

   // Transfer type: first beat never shows BUSY, it waits as IDLE instead.
   always_comb begin
      htrans = T_IDLE;
      if (state_q == S_ADDR) begin
         if (stall_wr) htrans = first_q ? T_IDLE : T_BUSY;
         else          htrans = first_q ? T_NONSEQ : T_SEQ;
      end
   end

   // Burst FSM: command capture, address pipeline, data-phase tracking, completion.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= S_IDLE;
         haddr_q    <= '0;
         wmask_q    <= '0;
         hsize_q    <= '0;
         hburst_q   <= '0;
         hwrite_q   <= 1'b0;
         wrap_q     <= 1'b0;
         first_q    <= 1'b0;
         left_q     <= '0;
         hwdata_q   <= '0;
         rd_data_q  <= '0;
         dph_q      <= 1'b0;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         done_q     <= 1'b0;
         done_err_q <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         done_err_q <= 1'b0;

         if (dph_done) begin
            dph_q <= 1'b0;
            if (!hwrite_q) begin
               rd_valid_q <= 1'b1;
               rd_data_q  <= bus.HRDATA;
               rd_err_q   <= bus.HRESP;
            end
         end
         if (dph_q && bus.HRESP) err_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  if (bus.cmd_size > 3'(MAX_SIZE)) begin
                     // unsupported size: report failure without touching the bus
                     done_q     <= 1'b1;
                     done_err_q <= 1'b1;
                  end else begin
                     haddr_q  <= bus.cmd_addr;
                     hsize_q  <= bus.cmd_size;
                     hburst_q <= bus.cmd_burst;
                     hwrite_q <= bus.cmd_write;
                     wrap_q   <= (bus.cmd_burst[0] == 1'b0) && (bus.cmd_burst != 3'd0);
                     wmask_q  <= cmd_mask;
                     left_q   <= cmd_beats;
                     first_q  <= 1'b1;
                     err_q    <= 1'b0;
                     state_q  <= S_ADDR;
                  end
               end
            end
            S_ADDR: begin
               if (ABORT && err_first) begin
                  // cancel: the pending address phase never completes, go quiet
                  state_q <= S_DRAIN;
               end else if (addr_go) begin
                  dph_q   <= 1'b1;
                  first_q <= 1'b0;
                  if (hwrite_q) hwdata_q <= bus.wd_data;
                  if (left_q == CNT_W'(1)) begin
                     state_q <= S_DRAIN;
                  end else begin
                     haddr_q <= haddr_d;
                     left_q  <= left_q - CNT_W'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (dph_done) begin
                  state_q    <= S_IDLE;
                  done_q     <= 1'b1;
                  done_err_q <= err_q | bus.HRESP;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.wd_ready  = addr_go & hwrite_q;
   assign bus.HTRANS    = htrans;
   assign bus.HADDR     = haddr_q;
   assign bus.HSIZE     = hsize_q;
   assign bus.HBURST    = hburst_q;
   assign bus.HWRITE    = hwrite_q;
   assign bus.HWDATA    = hwdata_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.rd_err    = rd_err_q;
   assign bus.done      = done_q;
   assign bus.done_err  = done_err_q;
endmodule
